// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back byte cache in front of a 32-bit-block data memory.
// Define DCACHE_STATS_EN to build saturating hit/miss counters; otherwise both read 0.
module data_cache #(
  parameter int SETS  = 8,
  parameter int TAG_W = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2,
    S_UPDATE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [SETS-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];
  logic [31:0]      fill_q;

  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [5:0]       mem_address_q, mem_address_d;
  logic [31:0]      mem_writedata_q, mem_writedata_d;

  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] addr_idx;
  logic [1:0]       addr_off;
  logic             req, hit, write_hit;

  assign addr_tag  = address[7 -: TAG_W];
  assign addr_idx  = address[2 +: IDX_W];
  assign addr_off  = address[1:0];
  assign req       = read | write;
  assign hit       = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  // A write (or read+write) request merges its byte only once the line is resident.
  assign write_hit = (state_q == S_IDLE) && write && hit;

  assign readdata      = data_q[addr_idx][{addr_off, 3'b000} +: 8];
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

  // Next-state and CPU stall
  always_comb begin
    state_d  = state_q;
    busywait = 1'b1;
    case (state_q)
      S_IDLE: begin
        busywait = 1'b0;
        if (req && !hit) begin
          busywait = 1'b1;
          state_d  = (valid_q[addr_idx] && dirty_q[addr_idx]) ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: if (!mem_busywait) state_d = S_FETCH;
      S_FETCH:     if (!mem_busywait) state_d = S_UPDATE;
      S_UPDATE:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Memory request lines are decoded from the next state so they leave a flop cleanly
  always_comb begin
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    case (state_d)
      S_WRITEBACK: begin
        mem_write_d     = 1'b1;
        mem_address_d   = {tag_q[addr_idx], addr_idx};
        mem_writedata_d = data_q[addr_idx];
      end
      S_FETCH: begin
        mem_read_d    = 1'b1;
        mem_address_d = {addr_tag, addr_idx};
      end
      default: ;
    endcase
  end

  // Control state: FSM, request registers, valid/dirty
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      valid_q         <= '0;
      dirty_q         <= '0;
    end else begin
      state_q         <= state_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      if (state_q == S_UPDATE) begin
        valid_q[addr_idx] <= 1'b1;
        dirty_q[addr_idx] <= 1'b0;
      end else if (write_hit) begin
        dirty_q[addr_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays: not cleared, but a reset edge must never land a partial update
  always_ff @(posedge clock) begin
    if (state_q == S_FETCH && !mem_busywait) fill_q <= mem_readdata;
    if (!reset) begin
      if (state_q == S_UPDATE) begin
        tag_q[addr_idx]  <= addr_tag;
        data_q[addr_idx] <= fill_q;
      end else if (write_hit) begin
        data_q[addr_idx][{addr_off, 3'b000} +: 8] <= writedata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;
  logic        post_update_q;

  // The hit that ends a miss sequence belongs to that miss, so it is not counted as a hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      post_update_q <= 1'b0;
    end else begin
      post_update_q <= (state_q == S_UPDATE);
      if (state_q == S_IDLE && req && hit && !post_update_q && hit_count_q != 16'hFFFF)
        hit_count_q <= hit_count_q + 16'd1;
      if (state_q == S_IDLE && req && !hit && miss_count_q != 16'hFFFF)
        miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif

endmodule
